wb_cache_arbiter: RTL and testbench
===================================

Name: wb_cache_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone arbiter. Successor to the two-port icache/dcache interconnect.
- Sits between the L1 caches (icache, dcache, and future prefetch/victim buffers) and the single L2 Wishbone port.
- Grants one master at a time for a whole transaction, using fixed-priority or round-robin arbitration.
- Masks responses so that only the granted master sees ACK/RTY/DAT_S.

Parameters:
- NUM_MASTERS, 2, number of requesting Wishbone masters (2..8).
- ADDR_W, 11, line address width (16-bit address, 32-byte lines).
- DATA_W, 256, line data width.
- SEL_W, DATA_W/8, byte-select width.
- ARB_MODE, 0, 0 = fixed priority (master 0 highest), 1 = round robin.
- TIMEOUT, 255, slave watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- m_CYC  in  NUM_MASTERS  per-master cycle.
- m_STB  in  NUM_MASTERS  per-master strobe.
- m_WE  in  NUM_MASTERS  per-master write enable.
- m_ADR  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_SEL  in  NUM_MASTERS*SEL_W  packed byte selects.
- m_DAT_M  in  NUM_MASTERS*DATA_W  packed write data.
- m_DAT_S  out  DATA_W  read data, broadcast to all masters.
- m_ACK  out  NUM_MASTERS  per-master acknowledge.
- m_RTY  out  NUM_MASTERS  per-master retry.
- s_CYC, s_STB, s_WE  out  1  slave-side controls.
- s_ADR  out  ADDR_W  slave address.
- s_SEL  out  SEL_W  slave byte select.
- s_DAT_M  out  DATA_W  slave write data.
- s_DAT_S  in  DATA_W  slave read data.
- s_ACK, s_RTY  in  1  slave responses.
- grant  out  NUM_MASTERS  one-hot current owner (debug/perf).

Behaviour:
- Reset (async, RST_N low): state=IDLE, grant=0, RR pointer=0, all s_* controls 0, m_ACK=0, m_RTY=0, s_ADR/s_SEL/s_DAT_M=0.
- Request definition: master i requests when m_CYC[i] & m_STB[i].
- IDLE:
  - If any master requests, the winner is registered into grant and the FSM goes to BUSY.
  - The slave sees s_CYC/s_STB one cycle after the request is first visible (1-cycle arbitration latency).
- BUSY:
  - s_* are a mux of the granted master's signals.
  - s_CYC = m_CYC[g] and s_STB = m_STB[g].
- Response routing:
  - m_ACK[g] = s_ACK and m_RTY[g] = s_RTY, combinational.
  - Non-granted masters always see ACK=0 and RTY=0.
  - m_DAT_S = s_DAT_S.
- Release:
  - On s_ACK or s_RTY in BUSY, the next state is IDLE and grant clears.
  - A master re-requesting takes at least one IDLE cycle, so there are no back-to-back grants without re-arbitration.
- Abort: if m_CYC[g] drops while BUSY with no ACK, go to IDLE the next cycle. s_CYC follows immediately (combinational).
- Fixed priority: the lowest-index requester wins.
- Round robin:
  - Search starts at index ptr.
  - On grant to master k, ptr <= (k+1) mod NUM_MASTERS.
  - Wrap-around is explicit for non-power-of-2 NUM_MASTERS.
- Simultaneous events:
  - A new request arriving in the same cycle as ACK is not granted until the next IDLE cycle.
  - ACK and RTY asserted together: ACK takes precedence and RTY is not forwarded.
- Single requester: granted regardless of mode; in round-robin mode ptr still advances.
- Reset asserted mid-transaction: all outputs drop asynchronously. The transaction is lost; masters must reissue.

Optional Feature:
- Macro: WB_CACHE_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle without s_ACK/s_RTY.
  - On reaching TIMEOUT: pulse m_RTY[g] for one cycle, drive s_CYC=0 that cycle, return to IDLE.
- Undefined: no counter. The arbiter waits indefinitely for the slave and TIMEOUT is unused.

Decomposition:
- Package wb_arb_types:
  - arb_state_t enum {IDLE, BUSY}.
  - Constants ARB_FIXED=0, ARB_RR=1.
  - lc3b line widths (ADDR_W/DATA_W defaults).
- Sub-module wb_rr_picker: combinational rotating-priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, winner index, valid.
  - ptr tied to 0 for fixed mode.

Test Plan:
1. Reset → grant=0, s_CYC=0, m_ACK=0. Release RST_N, then master 1 requests read adr 0x0A3 → s_CYC=1 and s_ADR=0x0A3 one cycle later; slave ACK with DAT_S=0xDEAD… → m_ACK=2'b10, m_ACK[0]=0.
2. ARB_MODE=0, NUM_MASTERS=2, both request continuously → master 0 wins every arbitration; master 1 is granted only once master 0 drops CYC.
3. ARB_MODE=1, NUM_MASTERS=3, all requesting, slave ACKs after 2 cycles → grant sequence 001, 010, 100, 001 (wrap).
4. Master 0 granted, drops m_CYC before ACK → s_CYC=0 the same cycle, IDLE next cycle; pending master 1 granted the cycle after.
5. With WB_CACHE_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ACKs → m_RTY[g] pulses exactly 8 BUSY cycles after grant, then grant=0.
6. RST_N pulsed low mid-BUSY write → s_CYC/s_STB/s_WE drop asynchronously and grant=0. After release, the same master's request is re-arbitrated normally.

Source files
------------

// File: rtl/wb_cache_arbiter_pkg.sv
// Shared types and constants for the L1-to-L2 Wishbone cache arbiter.
// Package name: wb_arb_types. It holds the arbiter state encoding, the
// arbitration-mode constants, the default line geometry, and a small
// modulo helper used for round-robin wrap-around.
package wb_arb_types;

    // Arbiter FSM states: waiting for a request, or owning the slave port.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Arbitration modes selected by the ARB_MODE parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Default lc3b line geometry: 16-bit byte address, 32-byte lines.
    localparam int LC3B_LINE_ADDR_W = 11;
    localparam int LC3B_LINE_DATA_W = 256;

    // Wrap an index that may be at most 2*n-2 back into 0..n-1. The
    // subtraction makes the wrap explicit, so it also holds when n is not
    // a power of two.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/wb_cache_arbiter_rr_picker.sv
// Rotating-priority encoder for the Wishbone cache arbiter.
// Scans the request vector starting at index ptr and wrapping past the top.
// The first requester found wins. With ptr tied to zero this becomes a plain
// fixed-priority encoder, where the lowest index wins.
module wb_rr_picker
    import wb_arb_types::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
)(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   valid
);

    logic [IDX_W-1:0] cand;

    // Walk the masters in rotated order; only the first requester is kept.
    always_comb begin
        cand       = '0;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'(rr_wrap(int'(ptr) + i, NUM_MASTERS));
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_cache_arbiter.sv
// N-master to 1-slave Wishbone arbiter between the L1 caches and the L2 port.
// - One master owns the slave for a whole transaction.
// - Ownership is decided in IDLE, so a grant takes effect one cycle after the
//   request appears.
// - Ownership is released on ACK, on RTY, or when the owner drops CYC.
// - Responses are steered only to the current owner.
// Optional build macro WB_CACHE_ARB_TIMEOUT_EN adds a slave watchdog. After
// TIMEOUT silent BUSY cycles it retries the owner and frees the port.
module wb_cache_arbiter
    import wb_arb_types::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = LC3B_LINE_ADDR_W,
    parameter int DATA_W      = LC3B_LINE_DATA_W,
    parameter int SEL_W       = DATA_W / 8,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int TIMEOUT     = 255
)(
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_MASTERS-1:0]        m_CYC,
    input  logic [NUM_MASTERS-1:0]        m_STB,
    input  logic [NUM_MASTERS-1:0]        m_WE,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_ADR,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_SEL,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_DAT_M,
    output logic [DATA_W-1:0]             m_DAT_S,
    output logic [NUM_MASTERS-1:0]        m_ACK,
    output logic [NUM_MASTERS-1:0]        m_RTY,
    output logic                          s_CYC,
    output logic                          s_STB,
    output logic                          s_WE,
    output logic [ADDR_W-1:0]             s_ADR,
    output logic [SEL_W-1:0]              s_SEL,
    output logic [DATA_W-1:0]             s_DAT_M,
    input  logic [DATA_W-1:0]             s_DAT_S,
    input  logic                          s_ACK,
    input  logic                          s_RTY,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    // Reject configurations outside the supported range at elaboration.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_cache_arbiter: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_cache_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t             state;
    logic [IDX_W-1:0]       gidx;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       pick_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   pick_valid;
    logic                   busy;
    logic                   slave_done;
    logic                   owner_cyc;
    logic                   wd_hit;

    assign req        = m_CYC & m_STB;
    assign busy       = (state == BUSY);
    assign slave_done = s_ACK | s_RTY;
    assign owner_cyc  = m_CYC[gidx];

    // In fixed-priority mode the search always starts at master 0.
    assign pick_ptr = (ARB_MODE == ARB_RR) ? ptr : '0;
    assign next_ptr = IDX_W'(rr_wrap(int'(pick_idx) + 1, NUM_MASTERS));

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (req),
        .ptr        (pick_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

`ifdef WB_CACHE_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Count BUSY cycles with no slave response. The count is held at zero
    // in IDLE, so every new ownership starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt <= '0;
        end else if (!busy) begin
            wd_cnt <= '0;
        end else if (!slave_done) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT-th silent BUSY cycle. A real response in that
    // same cycle wins over the watchdog.
    assign wd_hit = busy && !slave_done && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // Arbitration FSM. It grants in IDLE and releases on a response, an
    // abort, or the watchdog. There is always one IDLE cycle between grants.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= BUSY;
                        grant <= pick_onehot;
                        gidx  <= pick_idx;
                        if (ARB_MODE == ARB_RR) begin
                            ptr <= next_ptr;
                        end
                    end
                end
                BUSY: begin
                    if (slave_done || !owner_cyc || wd_hit) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Forward the owner's request to the slave. Everything is zero outside
    // BUSY. Controls also drop in the watchdog cycle.
    always_comb begin
        s_CYC   = busy & owner_cyc & ~wd_hit;
        s_STB   = busy & m_STB[gidx] & ~wd_hit;
        s_WE    = busy & m_WE[gidx] & ~wd_hit;
        s_ADR   = '0;
        s_SEL   = '0;
        s_DAT_M = '0;
        if (busy) begin
            s_ADR   = m_ADR[gidx*ADDR_W +: ADDR_W];
            s_SEL   = m_SEL[gidx*SEL_W +: SEL_W];
            s_DAT_M = m_DAT_M[gidx*DATA_W +: DATA_W];
        end
    end

    // Steer responses to the owner only; ACK masks a simultaneous RTY.
    always_comb begin
        m_ACK = '0;
        m_RTY = '0;
        if (busy) begin
            m_ACK[gidx] = s_ACK;
            m_RTY[gidx] = (s_RTY & ~s_ACK) | wd_hit;
        end
    end

    assign m_DAT_S = s_DAT_S;

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// Testbench for wb_cache_arbiter.
// Instance A is a two-master, fixed-priority arbiter with 256-bit lines.
// Instance B is a three-master, round-robin arbiter with 32-bit data.
// Expected slave requests and master responses are queued as stimulus is
// issued. Negedge monitors pop and compare them whenever the DUT presents
// them.
`timescale 1ns/1ps
module tb_wb_cache_arbiter;

    localparam int NA  = 2;
    localparam int AW  = 11;
    localparam int DW  = 256;
    localparam int SW  = DW / 8;
    localparam int NB  = 3;
    localparam int DWB = 32;
    localparam int SWB = DWB / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  grant;
        logic [10:0] adr;
        logic        we;
        logic [31:0] dat_lo;
    } sreq_t;

    typedef struct {
        logic [1:0]   ack;
        logic [1:0]   rty;
        logic [255:0] dat;
    } resp_t;

    sreq_t      a_sreq_q[$];
    resp_t      a_resp_q[$];
    logic [2:0] b_grant_q[$];

    // Instance A signals
    logic [NA-1:0]    a_cyc, a_stb, a_we;
    logic [NA*AW-1:0] a_adr;
    logic [NA*SW-1:0] a_sel;
    logic [NA*DW-1:0] a_datm;
    logic [DW-1:0]    a_m_dats;
    logic [NA-1:0]    a_m_ack, a_m_rty, a_grant;
    logic             a_s_cyc, a_s_stb, a_s_we;
    logic [AW-1:0]    a_s_adr;
    logic [SW-1:0]    a_s_sel;
    logic [DW-1:0]    a_s_datm, a_sdats;
    logic             a_sack, a_srty;
    logic             a_req_prev;

    // Instance B signals
    logic [NB-1:0]     b_cyc, b_stb, b_we;
    logic [NB*AW-1:0]  b_adr;
    logic [NB*SWB-1:0] b_sel;
    logic [NB*DWB-1:0] b_datm;
    logic [DWB-1:0]    b_m_dats;
    logic [NB-1:0]     b_m_ack, b_m_rty, b_grant;
    logic              b_s_cyc, b_s_stb, b_s_we;
    logic [AW-1:0]     b_s_adr;
    logic [SWB-1:0]    b_s_sel;
    logic [DWB-1:0]    b_s_datm, b_sdats;
    logic              b_sack, b_srty;

    logic [2:0] rr_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    wb_cache_arbiter #(
        .NUM_MASTERS (NA), .ADDR_W (AW), .DATA_W (DW), .SEL_W (SW),
        .ARB_MODE (0), .TIMEOUT (8)
    ) dut_a (
        .CLK (clk), .RST_N (rst_n),
        .m_CYC (a_cyc), .m_STB (a_stb), .m_WE (a_we), .m_ADR (a_adr),
        .m_SEL (a_sel), .m_DAT_M (a_datm), .m_DAT_S (a_m_dats),
        .m_ACK (a_m_ack), .m_RTY (a_m_rty),
        .s_CYC (a_s_cyc), .s_STB (a_s_stb), .s_WE (a_s_we), .s_ADR (a_s_adr),
        .s_SEL (a_s_sel), .s_DAT_M (a_s_datm), .s_DAT_S (a_sdats),
        .s_ACK (a_sack), .s_RTY (a_srty), .grant (a_grant)
    );

    wb_cache_arbiter #(
        .NUM_MASTERS (NB), .ADDR_W (AW), .DATA_W (DWB), .SEL_W (SWB),
        .ARB_MODE (1), .TIMEOUT (8)
    ) dut_b (
        .CLK (clk), .RST_N (rst_n),
        .m_CYC (b_cyc), .m_STB (b_stb), .m_WE (b_we), .m_ADR (b_adr),
        .m_SEL (b_sel), .m_DAT_M (b_datm), .m_DAT_S (b_m_dats),
        .m_ACK (b_m_ack), .m_RTY (b_m_rty),
        .s_CYC (b_s_cyc), .s_STB (b_s_stb), .s_WE (b_s_we), .s_ADR (b_s_adr),
        .s_SEL (b_s_sel), .s_DAT_M (b_s_datm), .s_DAT_S (b_sdats),
        .s_ACK (b_sack), .s_RTY (b_srty), .grant (b_grant)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A monitor: check each new slave request and each master response
    always @(negedge clk) begin
        sreq_t se;
        resp_t re;
        if (!rst_n) begin
            a_req_prev = 1'b0;
        end else begin
            if (a_s_cyc && a_s_stb && !a_req_prev) begin
                if (a_sreq_q.size() == 0) begin
                    chk("a_unexpected_sreq", a_grant, 0);
                end else begin
                    se = a_sreq_q.pop_front();
                    chk("a_sreq_grant", a_grant, se.grant);
                    chk("a_sreq_adr", a_s_adr, se.adr);
                    chk("a_sreq_we", a_s_we, se.we);
                    chk("a_sreq_dat", a_s_datm[31:0], se.dat_lo);
                end
            end
            a_req_prev = a_s_cyc && a_s_stb;
            if ((a_m_ack | a_m_rty) != 0) begin
                if (a_resp_q.size() == 0) begin
                    chk("a_unexpected_resp", a_m_ack | a_m_rty, 0);
                end else begin
                    re = a_resp_q.pop_front();
                    chk("a_resp_ack", a_m_ack, re.ack);
                    chk("a_resp_rty", a_m_rty, re.rty);
                    chk("a_resp_dat", a_m_dats, re.dat);
                end
            end
        end
    end

    // Instance B monitor: each ACK must go to the expected round-robin owner
    always @(negedge clk) begin
        logic [2:0] eg;
        if (rst_n && (b_m_ack | b_m_rty) != 0) begin
            if (b_grant_q.size() == 0) begin
                chk("b_unexpected_resp", b_m_ack | b_m_rty, 0);
            end else begin
                eg = b_grant_q.pop_front();
                chk("b_ack", b_m_ack, eg);
                chk("b_rty", b_m_rty, 0);
                chk("b_grant_at_ack", b_grant, eg);
            end
        end
    end

    initial begin
        a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_sel = '0;
        a_datm = {{8{32'h22221111}}, {8{32'h11110000}}};
        a_sdats = '0; a_sack = 1'b0; a_srty = 1'b0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_sel = '0;
        b_datm = '0; b_sdats = 32'hC0FFEE00; b_sack = 1'b0; b_srty = 1'b0;
        a_adr[0 +: AW]  = 11'h010;
        a_adr[AW +: AW] = 11'h0A3;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", a_grant, 0);
        chk("rst_s_cyc", a_s_cyc, 0);
        chk("rst_m_ack", a_m_ack, 0);
        chk("rst_s_adr", a_s_adr, 0);
        chk("rst_b_grant", b_grant, 0);
        rst_n = 1'b1;
        tick();

        // T1: master 1 read of 0x0A3, slave ACK with data
        a_cyc = 2'b10; a_stb = 2'b10; a_we = 2'b00;
        a_sreq_q.push_back(sreq_t'{2'b10, 11'h0A3, 1'b0, 32'h22221111});
        #1 chk("t1_idle_s_cyc", a_s_cyc, 0);
        tick();
        chk("t1_s_cyc", a_s_cyc, 1);
        chk("t1_s_adr", a_s_adr, 11'h0A3);
        chk("t1_grant", a_grant, 2'b10);
        a_sdats = {8{32'hDEADBEEF}}; a_sack = 1'b1;
        a_resp_q.push_back(resp_t'{2'b10, 2'b00, {8{32'hDEADBEEF}}});
        #1 chk("t1_m_ack", a_m_ack, 2'b10);
        tick();
        a_sack = 1'b0; a_cyc = '0; a_stb = '0;
        chk("t1_release_grant", a_grant, 0);
        tick();

        // T2: both request; master 0 wins each arbitration
        a_cyc = 2'b11; a_stb = 2'b11; a_we = 2'b01;
        a_sreq_q.push_back(sreq_t'{2'b01, 11'h010, 1'b1, 32'h11110000});
        tick();
        chk("t2_grant0", a_grant, 2'b01);
        a_sack = 1'b1; a_sdats = 256'h1234;
        a_resp_q.push_back(resp_t'{2'b01, 2'b00, 256'h1234});
        tick();
        a_sack = 1'b0;
        chk("t2_reidle_grant", a_grant, 0);
        a_sreq_q.push_back(sreq_t'{2'b01, 11'h010, 1'b1, 32'h11110000});
        tick();
        chk("t2_grant0_again", a_grant, 2'b01);
        a_sack = 1'b1; a_srty = 1'b1; a_sdats = 256'h5678;
        a_resp_q.push_back(resp_t'{2'b01, 2'b00, 256'h5678});
        #1 chk("t2_ack_over_rty", a_m_rty, 0);
        tick();
        a_sack = 1'b0; a_srty = 1'b0;
        a_cyc = 2'b10; a_stb = 2'b10; a_we = 2'b00;
        a_sreq_q.push_back(sreq_t'{2'b10, 11'h0A3, 1'b0, 32'h22221111});
        tick();
        chk("t2_grant1", a_grant, 2'b10);
        a_srty = 1'b1;
        a_resp_q.push_back(resp_t'{2'b00, 2'b10, 256'h5678});
        tick();
        a_srty = 1'b0; a_cyc = '0; a_stb = '0;
        chk("t2_rty_release", a_grant, 0);
        tick();

        // T4: master 0 aborts before ACK; master 1 follows after one IDLE
        a_cyc = 2'b11; a_stb = 2'b11;
        a_sreq_q.push_back(sreq_t'{2'b01, 11'h010, 1'b0, 32'h11110000});
        tick();
        chk("t4_grant0", a_grant, 2'b01);
        tick();
        chk("t4_wait_s_cyc", a_s_cyc, 1);
        a_cyc = 2'b10; a_stb = 2'b10;
        a_sreq_q.push_back(sreq_t'{2'b10, 11'h0A3, 1'b0, 32'h22221111});
        #1 chk("t4_abort_s_cyc", a_s_cyc, 0);
        chk("t4_abort_grant_held", a_grant, 2'b01);
        tick();
        chk("t4_idle_grant", a_grant, 0);
        tick();
        chk("t4_grant1", a_grant, 2'b10);
        a_sack = 1'b1; a_sdats = 256'hABCD;
        a_resp_q.push_back(resp_t'{2'b10, 2'b00, 256'hABCD});
        tick();
        a_sack = 1'b0; a_cyc = '0; a_stb = '0;
        tick();

`ifdef WB_CACHE_ARB_TIMEOUT_EN
        // T5: slave silent, watchdog retries master 1 in the 8th BUSY cycle
        a_cyc = 2'b10; a_stb = 2'b10;
        a_sreq_q.push_back(sreq_t'{2'b10, 11'h0A3, 1'b0, 32'h22221111});
        tick();
        chk("t5_grant", a_grant, 2'b10);
        for (int i = 1; i < 8; i++) begin
            chk("t5_early_rty", a_m_rty, 0);
            tick();
        end
        a_resp_q.push_back(resp_t'{2'b00, 2'b10, a_sdats});
        chk("t5_rty", a_m_rty, 2'b10);
        chk("t5_s_cyc", a_s_cyc, 0);
        tick();
        chk("t5_grant_clear", a_grant, 0);
        a_cyc = '0; a_stb = '0;
        tick();
`endif

        // T6: async reset during a BUSY write, then normal re-arbitration
        a_cyc = 2'b01; a_stb = 2'b01; a_we = 2'b01;
        a_sel[0 +: SW] = '1; a_adr[0 +: AW] = 11'h155;
        a_sreq_q.push_back(sreq_t'{2'b01, 11'h155, 1'b1, 32'h11110000});
        tick();
        chk("t6_s_we", a_s_we, 1);
        chk("t6_s_sel", a_s_sel, {SW{1'b1}});
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_s_cyc", a_s_cyc, 0);
        chk("t6_rst_s_stb", a_s_stb, 0);
        chk("t6_rst_s_we", a_s_we, 0);
        chk("t6_rst_grant", a_grant, 0);
        tick();
        rst_n = 1'b1;
        a_sreq_q.push_back(sreq_t'{2'b01, 11'h155, 1'b1, 32'h11110000});
        #1 chk("t6_post_rst_idle", a_grant, 0);
        tick();
        chk("t6_regrant", a_grant, 2'b01);
        a_sack = 1'b1; a_sdats = 256'h77;
        a_resp_q.push_back(resp_t'{2'b01, 2'b00, 256'h77});
        tick();
        a_sack = 1'b0; a_cyc = '0; a_stb = '0; a_we = '0;
        tick();

        // T3: round robin over three masters, ACK after two BUSY cycles
        b_cyc = 3'b111; b_stb = 3'b111;
        for (int k = 0; k < 4; k++) begin
            b_grant_q.push_back(rr_seq[k]);
            tick();
            chk("t3_rr_grant", b_grant, rr_seq[k]);
            tick();
            b_sack = 1'b1;
            tick();
            b_sack = 1'b0;
        end
        // Single requester still advances the pointer (to 0 after master 2)
        b_cyc = 3'b100; b_stb = 3'b100;
        b_grant_q.push_back(3'b100);
        tick();
        chk("t3_single_grant", b_grant, 3'b100);
        tick();
        b_sack = 1'b1;
        tick();
        b_sack = 1'b0;
        b_cyc = 3'b111; b_stb = 3'b111;
        b_grant_q.push_back(3'b001);
        tick();
        chk("t3_after_single", b_grant, 3'b001);
        tick();
        b_sack = 1'b1;
        tick();
        b_sack = 1'b0; b_cyc = '0; b_stb = '0;
        repeat (2) tick();

        chk("a_sreq_drain", a_sreq_q.size(), 0);
        chk("a_resp_drain", a_resp_q.size(), 0);
        chk("b_resp_drain", b_grant_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
